ts_ddr_write_packer: RTL and testbench

//  Consumer of the 6->50 MHz stbToMem FIFO in the record path. Pops 10-bit
//  {VALID,SYNC,DATA} entries, drops VALID=0, packs TS bytes little-endian into
//  32-bit words and issues Avalon-MM writes to the DDR3 write port at

---
 rtl/ts_ddr_write_packer.sv | 195 +++++++++++++++++++
 tb/tb_ts_ddr_write_packer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_ddr_write_packer.sv
// ts_ddr_write_packer
// Record-path consumer of the stbToMem FIFO. Pops {VALID,SYNC,DATA} entries,
// drops invalid ones, packs TS bytes little-endian into 32-bit words and writes
// them to the DDR3 Avalon-MM write port at consecutive word addresses. Every
// SYNC byte starts a new word in lane 0; a partially filled word ahead of it
// is written with only its filled lanes enabled.
module ts_ddr_write_packer #(
  parameter logic [23:0] BASE_ADDR = 24'h000000,
  parameter logic [23:0] DEPTH     = 24'hFFFFFF,
  parameter bit          WRAP      = 1'b0
) (
  input  logic        SYS_CLOCK,
  input  logic        SYS_RESET_N,
  input  logic        REC_START,
  input  logic        REC_STOP,
  input  logic [9:0]  FIFO_Q,
  input  logic        FIFO_EMPTY,
  output logic        FIFO_RDREQ,
  output logic [23:0] ddr_write_address,
  output logic        ddr_write_write,
  output logic [31:0] ddr_write_writedata,
  output logic [3:0]  ddr_write_byteenable,
  input  logic        ddr_write_waitrequest,
  output logic [23:0] WORDS_WRITTEN,
  output logic        BUSY,
  output logic        DONE,
  output logic        SYNC_ERR,
  output logic        OVERRUN
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [23:0] LAST_ADDR = BASE_ADDR + DEPTH - 24'd1;

  logic [2:0]  state;
  logic        rd_vld_p1;   // a pop was issued last cycle; FIFO_Q holds its entry now
  logic [1:0]  lanes;       // number of lanes already filled in pk_data
  logic [31:0] pk_data;     // word under assembly
  logic        hold_vld;    // SYNC byte parked while the partial word ahead of it drains
  logic [7:0]  hold_byte;
  logic        stop_req;
  logic        flush_wr;    // the write in progress is the final partial flush

  logic       ent_vld;
  logic       ent_sync;
  logic [7:0] ent_byte;

  function automatic logic [31:0] put_lane(input logic [31:0] w, input logic [1:0] ln,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[{ln, 3'b000} +: 8] = b;
    return r;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] n);
    logic [3:0] m;
    case (n)
      2'd1:    m = 4'h1;
      2'd2:    m = 4'h3;
      2'd3:    m = 4'h7;
      default: m = 4'h0;
    endcase
    return m;
  endfunction

  function automatic logic [23:0] sat_inc(input logic [23:0] v);
    return (v == 24'hFFFFFF) ? v : v + 24'd1;
  endfunction

  assign ent_vld  = rd_vld_p1 & FIFO_Q[9];
  assign ent_sync = FIFO_Q[8];
  assign ent_byte = FIFO_Q[7:0];

  // At most one read in flight, none once a stop has been requested.
  assign FIFO_RDREQ = (state == S_RUN) && !FIFO_EMPTY && !rd_vld_p1 && !stop_req && !REC_STOP;

  assign BUSY = (state != S_IDLE);
  assign DONE = (state == S_FIN);

  // FIFO read latency stage: marks the cycle in which FIFO_Q carries the popped entry
  always_ff @(posedge SYS_CLOCK or negedge SYS_RESET_N) begin
    if (!SYS_RESET_N) rd_vld_p1 <= 1'b0;
    else              rd_vld_p1 <= FIFO_RDREQ;
  end

  // Recording FSM: byte packing, Avalon write handshake, address/count/flag upkeep
  always_ff @(posedge SYS_CLOCK or negedge SYS_RESET_N) begin
    if (!SYS_RESET_N) begin
      state                <= S_IDLE;
      lanes                <= 2'd0;
      pk_data              <= 32'h0;
      hold_vld             <= 1'b0;
      hold_byte            <= 8'h0;
      stop_req             <= 1'b0;
      flush_wr             <= 1'b0;
      ddr_write_address    <= BASE_ADDR;
      ddr_write_write      <= 1'b0;
      ddr_write_writedata  <= 32'h0;
      ddr_write_byteenable <= 4'h0;
      WORDS_WRITTEN        <= 24'h0;
      SYNC_ERR             <= 1'b0;
      OVERRUN              <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (REC_START && !REC_STOP) begin
            state             <= S_RUN;
            WORDS_WRITTEN     <= 24'h0;
            SYNC_ERR          <= 1'b0;
            OVERRUN           <= 1'b0;
            lanes             <= 2'd0;
            pk_data           <= 32'h0;
            hold_vld          <= 1'b0;
            stop_req          <= 1'b0;
            flush_wr          <= 1'b0;
            ddr_write_address <= BASE_ADDR;
          end
        end

        S_RUN: begin
          if (REC_STOP) stop_req <= 1'b1;
          if (rd_vld_p1) begin
            if (ent_vld) begin
              if (ent_sync && (ent_byte != 8'h47)) SYNC_ERR <= 1'b1;
              if (ent_sync && (lanes != 2'd0)) begin
                // new packet: drain the partial word first, park the SYNC byte
                hold_vld             <= 1'b1;
                hold_byte            <= ent_byte;
                ddr_write_writedata  <= pk_data;
                ddr_write_byteenable <= lane_mask(lanes);
                ddr_write_write      <= 1'b1;
                state                <= S_WRITE;
              end else if (lanes == 2'd3) begin
                ddr_write_writedata  <= put_lane(pk_data, 2'd3, ent_byte);
                ddr_write_byteenable <= 4'hF;
                ddr_write_write      <= 1'b1;
                state                <= S_WRITE;
              end else begin
                pk_data <= put_lane(pk_data, lanes, ent_byte);
                lanes   <= lanes + 2'd1;
              end
            end
          end else if (stop_req || REC_STOP) begin
            state <= S_FLUSH;
          end
        end

        S_WRITE: begin
          if (REC_STOP) stop_req <= 1'b1;
          if (!ddr_write_waitrequest) begin
            ddr_write_write <= 1'b0;
            WORDS_WRITTEN   <= sat_inc(WORDS_WRITTEN);
            if (hold_vld) begin
              pk_data  <= {24'h0, hold_byte};
              lanes    <= 2'd1;
              hold_vld <= 1'b0;
            end else begin
              pk_data <= 32'h0;
              lanes   <= 2'd0;
            end
            if ((ddr_write_address == LAST_ADDR) && !WRAP) begin
              OVERRUN <= 1'b1;
              state   <= S_FIN;
            end else begin
              ddr_write_address <= (ddr_write_address == LAST_ADDR) ? BASE_ADDR
                                                                    : ddr_write_address + 24'd1;
              state             <= flush_wr ? S_FIN : S_RUN;
            end
          end
        end

        S_FLUSH: begin
          if (lanes != 2'd0) begin
            ddr_write_writedata  <= pk_data;
            ddr_write_byteenable <= lane_mask(lanes);
            ddr_write_write      <= 1'b1;
            flush_wr             <= 1'b1;
            state                <= S_WRITE;
          end else begin
            state <= S_FIN;
          end
        end

        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ts_ddr_write_packer.sv
// Directed bench for ts_ddr_write_packer: FIFO and Avalon slave models,
// a negedge monitor logging accepted writes, and hand-computed expectations.
module tb_ts_ddr_write_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rec_start, rec_stop, rec_start_b, rec_stop_b;

  // main DUT signals
  logic [9:0]  fifo_q;
  logic        fifo_empty, fifo_rdreq;
  logic [23:0] ddr_addr, words;
  logic        ddr_wr, ddr_wait, busy, done, sync_err, overrun;
  logic [31:0] ddr_data;
  logic [3:0]  ddr_be;

  // DEPTH=4 instances (b: WRAP=0, c: WRAP=1)
  logic [9:0]  fq_b, fq_c;
  logic        fe_b, fe_c, rq_b, rq_c;
  logic [23:0] addr_b, addr_c, ww_b, ww_c;
  logic        wr_b, wr_c, busy_b, busy_c, done_b, done_c, serr_b, serr_c, ovr_b, ovr_c;
  logic [31:0] wd_b, wd_c;
  logic [3:0]  be_b, be_c;

  int n_chk = 0;
  int n_err = 0;

  // FIFO models
  logic [9:0] mem [0:2047];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic [9:0] mem5 [0:63];
  int wp5 = 0;
  int rp_b = 0;
  int rp_c = 0;

  // Avalon slave stall model
  int acc_cnt = 0;
  int stall_seen = 0;
  int stall_word = -1;
  int stall_len = 5;

  // monitor state
  logic [23:0] log_addr [0:511];
  logic [31:0] log_data [0:511];
  logic [3:0]  log_be   [0:511];
  int log_n = 0;
  int wcyc = 0;
  int unstable = 0;
  int rd_in_wr = 0;
  int done_cnt = 0;
  int done_run = 0;
  int done_max = 0;
  logic        prev_wr = 1'b0;
  logic        prev_acc = 1'b0;
  logic [59:0] prev_sig = '0;
  logic [23:0] log_b_addr [0:15];
  logic [23:0] log_c_addr [0:15];
  logic [31:0] log_c_data [0:15];
  int log_b_n = 0;
  int log_c_n = 0;
  int done_b_cnt = 0;
  int done_c_cnt = 0;

  always #5 clk = ~clk;

  ts_ddr_write_packer u_dut (
    .SYS_CLOCK(clk), .SYS_RESET_N(rst_n), .REC_START(rec_start), .REC_STOP(rec_stop),
    .FIFO_Q(fifo_q), .FIFO_EMPTY(fifo_empty), .FIFO_RDREQ(fifo_rdreq),
    .ddr_write_address(ddr_addr), .ddr_write_write(ddr_wr), .ddr_write_writedata(ddr_data),
    .ddr_write_byteenable(ddr_be), .ddr_write_waitrequest(ddr_wait),
    .WORDS_WRITTEN(words), .BUSY(busy), .DONE(done), .SYNC_ERR(sync_err), .OVERRUN(overrun)
  );

  ts_ddr_write_packer #(.BASE_ADDR(24'h0), .DEPTH(24'd4), .WRAP(1'b0)) u_dut_b (
    .SYS_CLOCK(clk), .SYS_RESET_N(rst_n), .REC_START(rec_start_b), .REC_STOP(rec_stop_b),
    .FIFO_Q(fq_b), .FIFO_EMPTY(fe_b), .FIFO_RDREQ(rq_b),
    .ddr_write_address(addr_b), .ddr_write_write(wr_b), .ddr_write_writedata(wd_b),
    .ddr_write_byteenable(be_b), .ddr_write_waitrequest(1'b0),
    .WORDS_WRITTEN(ww_b), .BUSY(busy_b), .DONE(done_b), .SYNC_ERR(serr_b), .OVERRUN(ovr_b)
  );

  ts_ddr_write_packer #(.BASE_ADDR(24'h0), .DEPTH(24'd4), .WRAP(1'b1)) u_dut_c (
    .SYS_CLOCK(clk), .SYS_RESET_N(rst_n), .REC_START(rec_start_b), .REC_STOP(rec_stop_b),
    .FIFO_Q(fq_c), .FIFO_EMPTY(fe_c), .FIFO_RDREQ(rq_c),
    .ddr_write_address(addr_c), .ddr_write_write(wr_c), .ddr_write_writedata(wd_c),
    .ddr_write_byteenable(be_c), .ddr_write_waitrequest(1'b0),
    .WORDS_WRITTEN(ww_c), .BUSY(busy_c), .DONE(done_c), .SYNC_ERR(serr_c), .OVERRUN(ovr_c)
  );

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fe_b       = (rp_b == wp5);
  assign fe_c       = (rp_c == wp5);
  assign ddr_wait   = ddr_wr && (acc_cnt == stall_word) && (stall_seen < stall_len);

  // FIFO models: entry appears one cycle after the read request; junk otherwise
  always @(posedge clk) begin
    if (fifo_rdreq && (rd_ptr != wr_ptr)) begin
      fifo_q <= mem[rd_ptr[10:0]];
      rd_ptr <= rd_ptr + 1;
    end else fifo_q <= 10'h2EE;
    if (rq_b && (rp_b != wp5)) begin
      fq_b <= mem5[rp_b[5:0]];
      rp_b <= rp_b + 1;
    end else fq_b <= 10'h2EE;
    if (rq_c && (rp_c != wp5)) begin
      fq_c <= mem5[rp_c[5:0]];
      rp_c <= rp_c + 1;
    end else fq_c <= 10'h2EE;
    if (ddr_wr && !ddr_wait) acc_cnt <= acc_cnt + 1;
    if (ddr_wr && ddr_wait) stall_seen <= stall_seen + 1;
  end

  // monitor sampled on the inactive edge
  always @(negedge clk) begin
    if (ddr_wr && !ddr_wait) begin
      log_addr[log_n[8:0]] <= ddr_addr;
      log_data[log_n[8:0]] <= ddr_data;
      log_be[log_n[8:0]]   <= ddr_be;
      log_n <= log_n + 1;
    end
    if (ddr_wr && (log_n == stall_word)) wcyc <= wcyc + 1;
    if (ddr_wr && prev_wr && !prev_acc && ({ddr_addr, ddr_data, ddr_be} != prev_sig))
      unstable <= unstable + 1;
    prev_wr  <= ddr_wr;
    prev_acc <= ddr_wr && !ddr_wait;
    prev_sig <= {ddr_addr, ddr_data, ddr_be};
    if (fifo_rdreq && ddr_wr) rd_in_wr <= rd_in_wr + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_run <= done_run + 1;
      if (done_run + 1 > done_max) done_max <= done_run + 1;
    end else done_run <= 0;
    if (wr_b && (log_b_n < 16)) begin
      log_b_addr[log_b_n[3:0]] <= addr_b;
      log_b_n <= log_b_n + 1;
    end
    if (wr_c && (log_c_n < 16)) begin
      log_c_addr[log_c_n[3:0]] <= addr_c;
      log_c_data[log_c_n[3:0]] <= wd_c;
      log_c_n <= log_c_n + 1;
    end
    if (done_b) done_b_cnt <= done_b_cnt + 1;
    if (done_c) done_c_cnt <= done_c_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit v, input bit s, input logic [7:0] d);
    mem[wr_ptr[10:0]] = {v, s, d};
    wr_ptr++;
  endtask

  task automatic pulse_start();
    @(negedge clk) rec_start = 1'b1;
    @(negedge clk) rec_start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk) rec_stop = 1'b1;
    @(negedge clk) rec_stop = 1'b0;
  endtask

  task automatic wait_writes(input int target, input int budget);
    for (int i = 0; (i < budget) && (log_n < target); i++) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; (i < budget) && (rd_ptr != wr_ptr); i++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int i = 0; (i < budget) && (done_cnt == d0); i++) @(negedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] s1_byte(input int i);
    if (i == 0) return 8'h47;
    return 8'(i - 1);
  endfunction

  function automatic logic [31:0] s1_word(input int k);
    return {s1_byte(4*k+3), s1_byte(4*k+2), s1_byte(4*k+1), s1_byte(4*k)};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b0, d0;
    rst_n = 1'b0; rec_start = 1'b0; rec_stop = 1'b0; rec_start_b = 1'b0; rec_stop_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_write", 32'(ddr_wr), 32'h0);
    chk("rst_be", 32'(ddr_be), 32'h0);
    chk("rst_addr", 32'(ddr_addr), 32'h0);
    chk("rst_flags", {27'h0, busy, done, sync_err, overrun, fifo_rdreq}, 32'h0);
    chk("rst_words", 32'(words), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // START and STOP together: stay idle
    rec_start = 1'b1; rec_stop = 1'b1;
    @(negedge clk) rec_start = 1'b0; rec_stop = 1'b0;
    @(negedge clk);
    chk("start_stop_idle", 32'(busy), 32'h0);

    // 1: one 188-byte packet, no waitrequest
    b0 = log_n; d0 = done_cnt;
    for (int i = 0; i < 188; i++) push(1'b1, i == 0, s1_byte(i));
    pulse_start();
    wait_writes(b0 + 47, 3000);
    wait_drain(100);
    pulse_stop();
    wait_done(d0, 50);
    chk("s1_count", 32'(log_n - b0), 32'd47);
    chk("s1_word0", log_data[b0], 32'h02010047);
    chk("s1_word46", log_data[b0+46], 32'hBAB9B8B7);
    for (int k = 0; k < 47; k++) begin
      chk("s1_data", log_data[b0+k], s1_word(k));
      chk("s1_addr", 32'(log_addr[b0+k]), 32'(k));
      chk("s1_be", 32'(log_be[b0+k]), 32'hF);
    end
    chk("s1_words_written", 32'(words), 32'd47);
    chk("s1_done", 32'(done_cnt - d0), 32'd1);
    chk("s1_busy_after", 32'(busy), 32'h0);

    // 2: waitrequest held 5 cycles on word 2
    b0 = log_n; d0 = done_cnt;
    stall_word = acc_cnt + 2;
    push(1'b1, 1'b1, 8'h47);
    for (int i = 1; i < 16; i++) push(1'b1, 1'b0, 8'(i));
    pulse_start();
    wait_writes(b0 + 4, 500);
    wait_drain(100);
    pulse_stop();
    wait_done(d0, 50);
    chk("s2_count", 32'(log_n - b0), 32'd4);
    chk("s2_word0", log_data[b0], 32'h03020147);
    chk("s2_word1", log_data[b0+1], 32'h07060504);
    chk("s2_word2", log_data[b0+2], 32'h0B0A0908);
    chk("s2_word3", log_data[b0+3], 32'h0F0E0D0C);
    chk("s2_addr2", 32'(log_addr[b0+2]), 32'd2);
    chk("s2_stall_cycles", 32'(wcyc), 32'd6);
    chk("s2_stable", 32'(unstable), 32'd0);
    chk("s2_words_written", 32'(words), 32'd4);

    // 3: SYNC after three bytes forces a partial write
    b0 = log_n; d0 = done_cnt;
    push(1'b1, 1'b1, 8'h47); push(1'b1, 1'b0, 8'h11); push(1'b1, 1'b0, 8'h22);
    push(1'b1, 1'b1, 8'h47); push(1'b1, 1'b0, 8'h33); push(1'b1, 1'b0, 8'h44);
    push(1'b1, 1'b0, 8'h55);
    pulse_start();
    wait_writes(b0 + 2, 200);
    wait_drain(100);
    pulse_stop();
    wait_done(d0, 50);
    chk("s3_count", 32'(log_n - b0), 32'd2);
    chk("s3_word0", log_data[b0], 32'h00221147);
    chk("s3_be0", 32'(log_be[b0]), 32'h7);
    chk("s3_word1", log_data[b0+1], 32'h55443347);
    chk("s3_be1", 32'(log_be[b0+1]), 32'hF);
    chk("s3_addr1", 32'(log_addr[b0+1]), 32'd1);

    // 4: invalid entries interleaved 1:1
    b0 = log_n; d0 = done_cnt;
    for (int i = 0; i < 188; i++) begin
      push(1'b1, i == 0, s1_byte(i));
      push(1'b0, 1'b1, 8'h47);
    end
    pulse_start();
    wait_writes(b0 + 47, 4000);
    wait_drain(100);
    pulse_stop();
    wait_done(d0, 50);
    chk("s4_count", 32'(log_n - b0), 32'd47);
    chk("s4_word0", log_data[b0], 32'h02010047);
    for (int k = 0; k < 47; k++) chk("s4_data", log_data[b0+k], s1_word(k));
    chk("s4_words_written", 32'(words), 32'd47);

    // 6: stop after 6 bytes, bad SYNC byte
    b0 = log_n; d0 = done_cnt;
    push(1'b1, 1'b1, 8'h48);
    for (int i = 1; i < 6; i++) push(1'b1, 1'b0, 8'(i));
    pulse_start();
    wait_drain(100);
    chk("s6_before_stop", 32'(log_n - b0), 32'd1);
    pulse_stop();
    wait_done(d0, 50);
    chk("s6_count", 32'(log_n - b0), 32'd2);
    chk("s6_word0", log_data[b0], 32'h03020148);
    chk("s6_word1", log_data[b0+1], 32'h00000504);
    chk("s6_be1", 32'(log_be[b0+1]), 32'h3);
    chk("s6_addr1", 32'(log_addr[b0+1]), 32'd1);
    chk("s6_sync_err", 32'(sync_err), 32'd1);
    chk("s6_done_len", 32'(done_max), 32'd1);
    chk("s6_overrun", 32'(overrun), 32'd0);
    pulse_start();
    chk("s6_sync_err_clr", 32'(sync_err), 32'd0);
    chk("s6_words_clr", 32'(words), 32'd0);
    chk("s6_busy", 32'(busy), 32'd1);
    d0 = done_cnt;
    pulse_stop();
    wait_done(d0, 50);
    chk("s6_busy_after", 32'(busy), 32'd0);

    // 5: DEPTH=4, WRAP=0 and WRAP=1 side by side
    mem5[wp5[5:0]] = {1'b1, 1'b1, 8'h47}; wp5++;
    for (int i = 1; i < 20; i++) begin
      mem5[wp5[5:0]] = {2'b10, 8'(i)};
      wp5++;
    end
    @(negedge clk) rec_start_b = 1'b1;
    @(negedge clk) rec_start_b = 1'b0;
    for (int i = 0; (i < 600) && !((log_c_n >= 5) && (rp_c == wp5) && (done_b_cnt >= 1)); i++)
      @(negedge clk);
    repeat (4) @(negedge clk);
    @(negedge clk) rec_stop_b = 1'b1;
    @(negedge clk) rec_stop_b = 1'b0;
    for (int i = 0; (i < 50) && (done_c_cnt == 0); i++) @(negedge clk);
    @(negedge clk);
    chk("s5b_count", 32'(log_b_n), 32'd4);
    chk("s5b_addr3", 32'(log_b_addr[3]), 32'd3);
    chk("s5b_overrun", 32'(ovr_b), 32'd1);
    chk("s5b_done", 32'(done_b_cnt), 32'd1);
    chk("s5b_words", 32'(ww_b), 32'd4);
    chk("s5b_left_in_fifo", 32'(wp5 - rp_b), 32'd4);
    chk("s5c_count", 32'(log_c_n), 32'd5);
    chk("s5c_addr4", 32'(log_c_addr[4]), 32'd0);
    chk("s5c_word4", log_c_data[4], 32'h13121110);
    chk("s5c_overrun", 32'(ovr_c), 32'd0);
    chk("s5c_done", 32'(done_c_cnt), 32'd1);
    chk("s5c_words", 32'(ww_c), 32'd5);

    chk("rdreq_in_write", 32'(rd_in_wr), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
